decode_alu_pipe: RTL and testbench
==================================

# decode_alu_pipe

Registered, parametrised successor to the combinational ALU decoder. Accepts one RV32I instruction per cycle with its PC and register-file operands. Produces ALU operands, the ALU function select and destination info in a pipeline register between decode and execute. Adds over the combinational decoder: XLEN-wide datapath, valid/ready handshake with optional skid buffer, EX/MEM operand forwarding, flush, PC-relative ops (AUIPC/JAL/JALR), sign-extended load/store offsets and illegal-opcode flagging.

## Interface
- XLEN, 32, datapath width (>= 32); immediates sign-extend to XLEN.
- SKID, 1, 0: single output register; 1: two-entry skid buffer with registered `in_ready`.
- FWD_EN, 1, 0: forwarding ports ignored; 1: forwarding active.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  discard all held and incoming instructions.
- in_valid / in_ready  in / out  1 / 1  upstream handshake.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- rs1_val, rs2_val  in  XLEN  register-file read data, same cycle as `in_inst`.
- fwd_ex_en, fwd_ex_rd, fwd_ex_data  in  1, 5, XLEN  EX-stage result bypass.
- fwd_mem_en, fwd_mem_rd, fwd_mem_data  in  1, 5, XLEN  MEM-stage result bypass.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- out_op1, out_op2  out  XLEN  ALU operands.
- out_alu_sel  out  5  `ALU_*` code from defines.vh.
- out_rd  out  5  destination register; 0 for STORE/BRANCH.
- out_funct3  out  3  passthrough for branch/memory width.
- out_illegal  out  1  opcode not in the supported set.

## Operation
- Transfer occurs on each edge where valid && ready (both sides).
- Operand resolution happens on the input side, before capture:
  - For rs1 and rs2 independently: if index == 0, value = 0.
  - Else, if FWD_EN and fwd_ex_en and fwd_ex_rd == index, value = fwd_ex_data.
  - Else, if FWD_EN and fwd_mem_en and fwd_mem_rd == index, value = fwd_mem_data.
  - Else, value = the register-file read data. EX has priority over MEM.
- Decode of resolved values, by opcode:
  - OP: op1 = rs1, op2 = rs2; for funct3 ADD with inst[30] set, op2 = -rs2 (two's complement, XLEN bits) and sel = ALU_ADD.
  - OP_IMM: op2 = sext(imm12) for ADD/SLT/SLTU/XOR/OR/AND; op2 = zext(shamt) for SLL/SR.
  - OP and OP_IMM sel by funct3: SR selects SRA if inst[30], else SRL.
  - LOAD: op2 = sext(inst[31:20]); STORE: op2 = sext({inst[31:25], inst[11:7]}); both sel = ALU_ADD.
  - LUI: op1 = zext(inst[31:12]), op2 = 0, sel = ALU_LUI.
  - AUIPC: op1 = pc, op2 = sext({inst[31:12], 12'b0}), sel = ALU_ADD.
  - JAL, JALR: op1 = pc, op2 = 4, sel = ALU_ADD (link value).
  - BRANCH: op1 = rs1, op2 = rs2; BEQ/BNE select XOR, BLT/BGE select SLT, BLTU/BGEU select SLTU.
  - Unknown opcode or funct3: sel = ALU_NONE, op1 = op2 = 0. Unknown opcode also sets illegal = 1 and passes through as a normal beat.
- SKID=0: `in_ready = !out_valid || out_ready` (combinational).
- SKID=1: main register plus one spare entry.
  - `in_ready` is a flop equal to "spare empty".
  - When downstream stalls while a beat arrives, the beat goes to the spare entry.
  - The spare entry drains to main on the next out transfer.
  - Order is preserved.

## Timing
- Latency: 1 cycle, input transfer to `out_valid`. Throughput: 1 instruction/cycle with `out_ready` held high.
- Reset (rst_n low at edge): `out_valid` = 0, all out_* data = 0, skid empty. `in_ready` = 1 in the cycle after reset.
- Reset has priority over flush; flush has priority over transfers.
- flush high at an edge: `out_valid` = 0 and skid empty after that edge. A beat offered in the flush cycle is dropped, not captured. `in_ready` = 1 in the next cycle.
- Simultaneous out transfer and in transfer with SKID=1 and spare empty: the new beat goes straight to main, spare stays empty.
- Full (SKID=1, both entries occupied): `in_ready` = 0 until `out_ready` is seen.
- Output data holds stable while `out_valid` && !`out_ready`.
- Forwarding inputs are sampled only in the capture cycle. Held beats are not re-resolved.
- reset or flush mid-stall discards both entries.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093) -> next cycle: `out_valid` = 1, op1 = 0, op2 = 0xFFFFFFFF, sel = ALU_ADD, rd = 1.
- SUB x3,x1,x2 (0x402081B3) with rs1_val = 10, rs2_val = 5 -> op1 = 10, op2 = 0xFFFFFFFB, sel = ALU_ADD.
- ADD x3,x1,x2 (0x002081B3) with fwd_ex(rd1 = 0x1234) and fwd_mem(rd1 = 0x9999, rd2 = 0x55) -> op1 = 0x1234, op2 = 0x55. Repeat with rd = 0 on both forwarding ports -> values from the register file.
- AUIPC x1,0x12345 (0x12345097), pc = 0x100 -> op1 = 0x100, op2 = 0x12345000. SW with offset -4 (0xFE112E23) -> op2 = 0xFFFFFFFC.
- SKID=1: stream 4 beats with `out_ready` low for 3 cycles -> `in_ready` drops after 2 accepted beats. All 4 emerge in order with no duplicates; data stays stable while stalled.
- Stall with 2 beats held, assert flush with in_valid high -> next cycle `out_valid` = 0, `in_ready` = 1, and no flushed beat ever appears at the output. Opcode 0x7F -> illegal = 1, sel = ALU_NONE.

Source files
------------

// File: rtl/decode_alu_pipe.sv
// Decode stage for RV32I: resolves operands (with EX/MEM bypass), decodes ALU
// operands and function select, and holds the result in a decode/execute pipeline register.
module decode_alu_pipe #(
    parameter int XLEN   = 32,
    parameter bit SKID   = 1'b1,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            fwd_ex_en,
    input  logic [4:0]      fwd_ex_rd,
    input  logic [XLEN-1:0] fwd_ex_data,
    input  logic            fwd_mem_en,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_alu_sel,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
);
    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // beat layout: {illegal, funct3, rd, sel, op2, op1}
    localparam int BW = 2 * XLEN + 14;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] resolve(input logic [4:0] idx,
                                                input logic [XLEN-1:0] rf_val);
        if (idx == 5'd0) begin
            resolve = {XLEN{1'b0}};
        end else if (FWD_EN && fwd_ex_en && (fwd_ex_rd == idx)) begin
            resolve = fwd_ex_data;
        end else if (FWD_EN && fwd_mem_en && (fwd_mem_rd == idx)) begin
            resolve = fwd_mem_data;
        end else begin
            resolve = rf_val;
        end
    endfunction

    function automatic logic [4:0] f3_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_sel = ALU_ADD;
            3'b001:  f3_sel = ALU_SLL;
            3'b010:  f3_sel = ALU_SLT;
            3'b011:  f3_sel = ALU_SLTU;
            3'b100:  f3_sel = ALU_XOR;
            3'b101:  f3_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_sel = ALU_OR;
            3'b111:  f3_sel = ALU_AND;
            default: f3_sel = ALU_NONE;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [XLEN-1:0] rs1_r, rs2_r, imm_i, imm_s, imm_u, shamt;
    logic [XLEN-1:0] dec_op1, dec_op2;
    logic [4:0]      dec_sel, dec_rd;
    logic            dec_illegal;
    logic [BW-1:0]   dec_beat;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign rs1_r  = resolve(in_inst[19:15], rs1_val);
    assign rs2_r  = resolve(in_inst[24:20], rs2_val);
    assign imm_i  = sext32({{20{in_inst[31]}}, in_inst[31:20]});
    assign imm_s  = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
    assign imm_u  = sext32({in_inst[31:12], 12'h000});
    assign shamt  = XLEN'(in_inst[24:20]);

    // Instruction decode into ALU operands, function select and destination
    always_comb begin
        dec_op1     = {XLEN{1'b0}};
        dec_op2     = {XLEN{1'b0}};
        dec_sel     = ALU_NONE;
        dec_rd      = in_inst[11:7];
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op1 = rs1_r;
                dec_op2 = ((f3 == 3'b000) && in_inst[30]) ? ({XLEN{1'b0}} - rs2_r) : rs2_r;
                dec_sel = f3_sel(f3, in_inst[30]);
            end
            OPC_OP_IMM: begin
                dec_op1 = rs1_r;
                dec_op2 = ((f3 == 3'b001) || (f3 == 3'b101)) ? shamt : imm_i;
                dec_sel = f3_sel(f3, in_inst[30]);
            end
            OPC_LOAD: begin
                if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) begin
                    dec_sel = ALU_NONE;
                end else begin
                    dec_op1 = rs1_r;
                    dec_op2 = imm_i;
                    dec_sel = ALU_ADD;
                end
            end
            OPC_STORE: begin
                dec_rd = 5'd0;
                if (f3 <= 3'b010) begin
                    dec_op1 = rs1_r;
                    dec_op2 = imm_s;
                    dec_sel = ALU_ADD;
                end else begin
                    dec_sel = ALU_NONE;
                end
            end
            OPC_LUI: begin
                dec_op1 = XLEN'(in_inst[31:12]);
                dec_sel = ALU_LUI;
            end
            OPC_AUIPC: begin
                dec_op1 = in_pc;
                dec_op2 = imm_u;
                dec_sel = ALU_ADD;
            end
            OPC_JAL: begin
                dec_op1 = in_pc;
                dec_op2 = XLEN'(4'd4);
                dec_sel = ALU_ADD;
            end
            OPC_JALR: begin
                if (f3 == 3'b000) begin
                    dec_op1 = in_pc;
                    dec_op2 = XLEN'(4'd4);
                    dec_sel = ALU_ADD;
                end else begin
                    dec_sel = ALU_NONE;
                end
            end
            OPC_BRANCH: begin
                dec_rd = 5'd0;
                case (f3)
                    3'b000, 3'b001: dec_sel = ALU_XOR;
                    3'b100, 3'b101: dec_sel = ALU_SLT;
                    3'b110, 3'b111: dec_sel = ALU_SLTU;
                    default:        dec_sel = ALU_NONE;
                endcase
                if (dec_sel != ALU_NONE) begin
                    dec_op1 = rs1_r;
                    dec_op2 = rs2_r;
                end else begin
                    dec_op1 = {XLEN{1'b0}};
                end
            end
            default: begin
                dec_illegal = 1'b1;
                dec_rd      = 5'd0;
            end
        endcase
    end

    assign dec_beat = {dec_illegal, f3, dec_rd, dec_sel, dec_op2, dec_op1};

    logic [BW-1:0] main_q, main_d, spare_q, spare_d;
    logic          main_valid_q, main_valid_d, spare_valid_q, spare_valid_d;
    logic          in_ready_q;
    logic          in_fire, out_fire;

    assign in_ready = SKID ? in_ready_q : (!main_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready;

    // Main/spare occupancy: spare only fills when main is held by a stall
    always_comb begin
        main_d        = main_q;
        spare_d       = spare_q;
        main_valid_d  = main_valid_q;
        spare_valid_d = spare_valid_q;
        if (flush) begin
            main_valid_d  = 1'b0;
            spare_valid_d = 1'b0;
        end else if (spare_valid_q) begin
            if (out_fire) begin
                main_d        = spare_q;
                spare_valid_d = 1'b0;
            end else begin
                spare_valid_d = 1'b1;
            end
        end else if (in_fire) begin
            if (main_valid_q && !out_ready) begin
                spare_d       = dec_beat;
                spare_valid_d = 1'b1;
            end else begin
                main_d       = dec_beat;
                main_valid_d = 1'b1;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end else begin
            main_valid_d = main_valid_q;
        end
    end

    // Pipeline register state with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q        <= {BW{1'b0}};
            spare_q       <= {BW{1'b0}};
            main_valid_q  <= 1'b0;
            spare_valid_q <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            main_q        <= main_d;
            spare_q       <= spare_d;
            main_valid_q  <= main_valid_d;
            spare_valid_q <= spare_valid_d;
            in_ready_q    <= !spare_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_op1     = main_q[XLEN-1:0];
    assign out_op2     = main_q[2*XLEN-1:XLEN];
    assign out_alu_sel = main_q[2*XLEN+4:2*XLEN];
    assign out_rd      = main_q[2*XLEN+9:2*XLEN+5];
    assign out_funct3  = main_q[2*XLEN+12:2*XLEN+10];
    assign out_illegal = main_q[2*XLEN+13];

endmodule

// File: tb/tb_decode_alu_pipe.sv
// Directed self-checking bench for decode_alu_pipe (SKID=1, FWD_EN=1, XLEN=32).
module tb_decode_alu_pipe;
    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] in_inst, in_pc, rs1_val, rs2_val;
    logic        fwd_ex_en, fwd_mem_en;
    logic [4:0]  fwd_ex_rd, fwd_mem_rd;
    logic [31:0] fwd_ex_data, fwd_mem_data;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_alu_sel, out_rd;
    logic [2:0]  out_funct3;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    decode_alu_pipe #(.XLEN(32), .SKID(1'b1), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .fwd_ex_en(fwd_ex_en), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_alu_sel(out_alu_sel),
        .out_rd(out_rd), .out_funct3(out_funct3), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        in_inst   = inst;
        in_pc     = pc;
        rs1_val   = r1;
        rs2_val   = r2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    function automatic logic [31:0] addi_x1(input logic [11:0] k);
        addi_x1 = {k, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    logic [31:0] seen[$];
    int          idx, acc, vcount;
    logic        in_f, out_f;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
        fwd_ex_en = 1'b0; fwd_ex_rd = 5'd0; fwd_ex_data = 32'h0;
        fwd_mem_en = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h0;
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op2", out_op2, 32'd0);
        check("rst_sel", {27'd0, out_alu_sel}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send(32'hFFF00093, 32'h0, 32'h0, 32'h0);
        check("addi_valid", {31'd0, out_valid}, 32'd1);
        check("addi_op1", out_op1, 32'h0);
        check("addi_op2", out_op2, 32'hFFFFFFFF);
        check("addi_sel", {27'd0, out_alu_sel}, {27'd0, ALU_ADD});
        check("addi_rd", {27'd0, out_rd}, 32'd1);

        send(32'h402081B3, 32'h0, 32'd10, 32'd5);
        check("sub_op1", out_op1, 32'd10);
        check("sub_op2", out_op2, 32'hFFFFFFFB);
        check("sub_sel", {27'd0, out_alu_sel}, {27'd0, ALU_ADD});
        check("sub_rd", {27'd0, out_rd}, 32'd3);

        fwd_ex_en = 1'b1; fwd_ex_rd = 5'd1; fwd_ex_data = 32'h1234;
        fwd_mem_en = 1'b1; fwd_mem_rd = 5'd2; fwd_mem_data = 32'h55;
        send(32'h002081B3, 32'h0, 32'h11, 32'h22);
        check("fwd_ex_op1", out_op1, 32'h1234);
        check("fwd_mem_op2", out_op2, 32'h55);
        fwd_mem_rd = 5'd1; fwd_mem_data = 32'h9999;
        send(32'h002081B3, 32'h0, 32'h11, 32'h22);
        check("fwd_prio_op1", out_op1, 32'h1234);
        check("fwd_prio_op2", out_op2, 32'h22);
        fwd_ex_rd = 5'd0; fwd_mem_rd = 5'd0;
        send(32'h002081B3, 32'h0, 32'h11, 32'h22);
        check("fwd_rd0_op1", out_op1, 32'h11);
        check("fwd_rd0_op2", out_op2, 32'h22);
        send(32'h002001B3, 32'h0, 32'h77, 32'h22);
        check("x0_op1", out_op1, 32'h0);
        fwd_ex_en = 1'b0; fwd_mem_en = 1'b0;

        send(32'h12345097, 32'h100, 32'h0, 32'h0);
        check("auipc_op1", out_op1, 32'h100);
        check("auipc_op2", out_op2, 32'h12345000);
        send(32'hFE112E23, 32'h0, 32'h1000, 32'h0);
        check("sw_op1", out_op1, 32'h1000);
        check("sw_op2", out_op2, 32'hFFFFFFFC);
        check("sw_rd", {27'd0, out_rd}, 32'd0);
        check("sw_f3", {29'd0, out_funct3}, 32'd2);
        send(32'h123450B7, 32'h0, 32'h0, 32'h0);
        check("lui_op1", out_op1, 32'h12345);
        check("lui_sel", {27'd0, out_alu_sel}, {27'd0, ALU_LUI});
        send(32'h000000EF, 32'h200, 32'h0, 32'h0);
        check("jal_op1", out_op1, 32'h200);
        check("jal_op2", out_op2, 32'd4);
        send(32'h00208063, 32'h0, 32'hA, 32'hB);
        check("beq_sel", {27'd0, out_alu_sel}, {27'd0, ALU_XOR});
        check("beq_rd", {27'd0, out_rd}, 32'd0);
        send(32'h0020C063, 32'h0, 32'hA, 32'hB);
        check("blt_sel", {27'd0, out_alu_sel}, {27'd0, ALU_SLT});
        send(32'h4030D093, 32'h0, 32'h80, 32'h0);
        check("srai_op2", out_op2, 32'd3);
        check("srai_sel", {27'd0, out_alu_sel}, {27'd0, ALU_SRA});
        tick();

        // skid: four beats, downstream stalled for three cycles
        idx = 0; acc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (idx < 4);
            in_inst   = addi_x1(12'(idx + 1));
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (out_f) seen.push_back(out_op2);
            if (cyc == 2) begin
                check("skid_full_rdy", {31'd0, in_ready}, 32'd0);
                check("skid_accepted", 32'(acc), 32'd2);
                check("skid_stable_op2", out_op2, 32'd1);
            end
            tick();
            if (in_f) begin
                idx++;
                acc++;
            end
        end
        in_valid = 1'b0;
        check("skid_count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) check("skid_order", seen[i], 32'(i + 1));
            else check("skid_order_missing", 32'hFFFFFFFF, 32'(i + 1));
        end

        // flush while stalled with two held beats
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = addi_x1(12'd5);
        tick();
        in_inst = addi_x1(12'd6);
        tick();
        check("pre_flush_rdy", {31'd0, in_ready}, 32'd0);
        in_inst = addi_x1(12'd7); flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        in_inst = addi_x1(12'd8); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        vcount = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (out_valid) vcount++;
            tick();
        end
        check("flush_no_output", 32'(vcount), 32'd0);

        // reset mid-stall discards both entries
        out_ready = 1'b0; in_valid = 1'b1; in_inst = addi_x1(12'd9);
        tick();
        in_inst = addi_x1(12'd10);
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        check("rst_stall_op2", out_op2, 32'd0);
        check("rst_stall_rdy", {31'd0, in_ready}, 32'd1);

        send(32'h0000007F, 32'h0, 32'h5, 32'h6);
        check("ill_valid", {31'd0, out_valid}, 32'd1);
        check("ill_flag", {31'd0, out_illegal}, 32'd1);
        check("ill_sel", {27'd0, out_alu_sel}, {27'd0, ALU_NONE});
        check("ill_op1", out_op1, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
